// File: rtl/common.sv
// Shared types for the UART program loader.
//   loader_state_type  : loader FSM states (length header, data, finished)
//   uart_rx_state_type : serial receiver states
package common;

    typedef enum logic [1:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE
    } loader_state_type;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_rx_state_type;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver.
//   clk, reset          : system clock, async active-high reset
//   io_rx               : asynchronous serial line, idle high
//   byte_valid          : 1-cycle pulse, byte_data holds the received byte
//   byte_data           : last good byte
//   frame_error_pulse   : 1-cycle pulse when a stop bit samples low
module uart_rx
    import common::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error_pulse
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_rx_state_type state;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= RX_IDLE;
            rx_meta           <= 1'b1;
            rx_sync           <= 1'b1;
            rx_prev           <= 1'b1;
            cnt               <= '0;
            bit_idx           <= '0;
            shift_reg         <= '0;
            byte_valid        <= 1'b0;
            byte_data         <= '0;
            frame_error_pulse <= 1'b0;
        end else begin
            rx_meta           <= io_rx;
            rx_sync           <= rx_meta;
            rx_prev           <= rx_sync;
            byte_valid        <= 1'b0;
            frame_error_pulse <= 1'b0;
            case (state)
                RX_IDLE: begin
                    // falling edge on the synchronized line marks a start bit
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // line back high at mid start bit: glitch, not a frame
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_CNT) begin
                        cnt       <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_CNT) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift_reg;
                        end else begin
                            frame_error_pulse <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a 16-bit little-endian word count followed by the
// image bytes over UART, packs them into little-endian 32-bit words and
// writes them to program memory from address 0, holding the CPU meanwhile.
//   clk, reset            : system clock, async active-high reset
//   io_rx                 : serial input
//   prog_write_enable     : 1-cycle write strobe
//   prog_address          : byte address of the write
//   prog_write_data       : assembled word
//   load_active/load_done : CPU hold / image complete
//   frame_error           : sticky, bad stop bit seen
//   length_error          : sticky, header count exceeded MEM_WORDS
module uart_program_loader
    import common::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int MEM_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rx,
    output logic        prog_write_enable,
    output logic [31:0] prog_address,
    output logic [31:0] prog_write_data,
    output logic        load_active,
    output logic        load_done,
    output logic        frame_error,
    output logic        length_error
);

    localparam int          CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam logic [16:0] MAX_WORDS    = 17'(MEM_WORDS);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_error_pulse;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk               (clk),
        .reset             (reset),
        .io_rx             (io_rx),
        .byte_valid        (byte_valid),
        .byte_data         (byte_data),
        .frame_error_pulse (frame_error_pulse)
    );

    loader_state_type state;
    logic [7:0]       len_lo;
    logic [15:0]      num_words;
    logic [15:0]      word_index;
    logic [1:0]       byte_idx;
    logic [31:0]      word_buf;
    logic [15:0]      len_word;

    assign len_word = {byte_data, len_lo};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= LEN_LO;
            len_lo            <= '0;
            num_words         <= '0;
            word_index        <= '0;
            byte_idx          <= '0;
            word_buf          <= '0;
            prog_write_enable <= 1'b0;
            prog_address      <= '0;
            prog_write_data   <= '0;
            load_active       <= 1'b1;
            load_done         <= 1'b0;
            frame_error       <= 1'b0;
            length_error      <= 1'b0;
        end else begin
            prog_write_enable <= 1'b0;
            if (frame_error_pulse) frame_error <= 1'b1;
            case (state)
                LEN_LO: begin
                    if (byte_valid) begin
                        len_lo <= byte_data;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (byte_valid) begin
                        if (len_word == 16'd0) begin
                            // empty image: release immediately
                            state       <= DONE;
                            load_active <= 1'b0;
                            load_done   <= 1'b1;
                        end else if ({1'b0, len_word} > MAX_WORDS) begin
                            length_error <= 1'b1;
                            state        <= LEN_LO;
                        end else begin
                            num_words  <= len_word;
                            word_index <= '0;
                            byte_idx   <= '0;
                            state      <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            prog_write_enable <= 1'b1;
                            prog_address      <= {14'd0, word_index, 2'b00};
                            prog_write_data   <= {byte_data, word_buf[23:0]};
                            word_index        <= word_index + 1'b1;
                            // release flags follow from DONE one cycle after the strobe
                            if (word_index == num_words - 16'd1) state <= DONE;
                        end else begin
                            word_buf[{byte_idx, 3'b000} +: 8] <= byte_data;
                        end
                    end
                end
                DONE: begin
                    load_active <= 1'b0;
                    load_done   <= 1'b1;
                end
                default: state <= LEN_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

    localparam int CLK_NS    = 10;
    localparam int BIT_NS    = 16 * CLK_NS;
    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_rx = 1'b1;
    logic        prog_write_enable;
    logic [31:0] prog_address;
    logic [31:0] prog_write_data;
    logic        load_active;
    logic        load_done;
    logic        frame_error;
    logic        length_error;

    uart_program_loader #(
        .CLK_FREQ_HZ(16),
        .BAUD_RATE  (1),
        .MEM_WORDS  (MEM_WORDS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .io_rx            (io_rx),
        .prog_write_enable(prog_write_enable),
        .prog_address     (prog_address),
        .prog_write_data  (prog_write_data),
        .load_active      (load_active),
        .load_done        (load_done),
        .frame_error      (frame_error),
        .length_error     (length_error)
    );

    always #(CLK_NS / 2) clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];        // {address, data} of each expected write
    logic [7:0]  stim[$];         // bytes to put on the line
    bit          exp_done, exp_lerr, done_after_bytes;
    int          cyc = 0, last_strobe_cyc = -100, last_bv_cyc = -100, bv_count = 0;
    logic        prev_done = 1'b0;
    logic [63:0] e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe and checks release timing.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (dut.byte_valid) begin
                bv_count++;
                last_bv_cyc = cyc;
            end
            if (prog_write_enable) begin
                last_strobe_cyc = cyc;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             prog_address, prog_write_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", prog_address, e[63:32]);
                    chk("write_data", prog_write_data, e[31:0]);
                end
            end
            if (load_done && !prev_done) begin
                chk("done_latency", cyc - (done_after_bytes ? last_bv_cyc : last_strobe_cyc), 1);
                chk("active_with_done", load_active, 1'b0);
            end
        end
        prev_done = reset ? 1'b0 : load_done;
    end

    // Reference: walk the good-byte stream as header + payload.
    task automatic model(input logic [7:0] b[$]);
        int pos = 0;
        int n;
        exp_done = 0;
        exp_lerr = 0;
        done_after_bytes = 0;
        while (pos + 2 <= b.size()) begin
            n = {b[pos + 1], b[pos]};
            pos += 2;
            if (n == 0) begin
                exp_done = 1;
                done_after_bytes = 1;
                break;
            end
            if (n > MEM_WORDS) begin
                exp_lerr = 1;
                continue;
            end
            for (int w = 0; w < n && pos + 4 <= b.size(); w++) begin
                exp_q.push_back({32'(w * 4), b[pos + 3], b[pos + 2], b[pos + 1], b[pos]});
                pos += 4;
                if (w == n - 1) exp_done = 1;
            end
            break;
        end
    endtask

    task automatic put_bytes(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) stim.push_back(v[8 * (n - 1 - i) +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #2;
        io_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            io_rx = b[i];
            #(BIT_NS);
        end
        io_rx = stop;
        #(BIT_NS);
        io_rx = 1'b1;
        #(BIT_NS);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_we", prog_write_enable, 1'b0);
        chk("rst_addr", prog_address, 32'd0);
        chk("rst_data", prog_write_data, 32'd0);
        chk("rst_active", load_active, 1'b1);
        chk("rst_done", load_done, 1'b0);
        chk("rst_ferr", frame_error, 1'b0);
        chk("rst_lerr", length_error, 1'b0);
        exp_q.delete();
        io_rx = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    // Send stim (byte index bad gets a low stop bit), then check the final state.
    task automatic run(input int bad);
        logic [7:0] good[$];
        for (int i = 0; i < stim.size(); i++) if (i != bad) good.push_back(stim[i]);
        model(good);
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i], (i == bad) ? 1'b0 : 1'b1);
        for (int i = 0; i < 200 && exp_done && !load_done; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("pending_writes", exp_q.size(), 0);
        chk("load_done", load_done, exp_done);
        chk("load_active", load_active, !exp_done);
        chk("length_error", length_error, exp_lerr);
        chk("frame_error", frame_error, (bad >= 0));
        stim.delete();
    endtask

    initial begin
        int n;
        int bv0;
        do_reset();

        put_bytes(128'h02_00_EF_BE_AD_DE_78_56_34_12, 10);
        run(-1);

        do_reset();
        put_bytes(128'h00_00, 2);
        run(-1);

        do_reset();
        put_bytes(128'h01_00_AA_11_22_33_44, 7);
        run(2);

        do_reset();
        bv0 = bv_count;
        @(posedge clk);
        #2;
        io_rx = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        io_rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_byte", bv_count - bv0, 0);
        put_bytes(128'h01_04_01_00_A1_B2_C3_D4, 8);
        run(-1);

        do_reset();
        put_bytes(128'h01_00_11_22, 4);
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i], 1'b1);
        stim.delete();
        do_reset();
        put_bytes(128'h01_00_55_66_77_88, 6);
        run(-1);

        for (int t = 0; t < 3; t++) begin
            do_reset();
            n = $urandom_range(1, 3);
            stim.push_back(8'(n));
            stim.push_back(8'h00);
            for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
            run(-1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
